// File: rtl/ir_nec_pkg.sv
// Shared state encoding and NEC unit-count constants for the IR transmitter.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEADER_MARK,
    LEADER_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP,
    REP_SPACE
  } nec_state_e;

  localparam int LEADER_MARK_U  = 16;
  localparam int LEADER_SPACE_U = 8;
  localparam int ZERO_SPACE_U   = 1;
  localparam int ONE_SPACE_U    = 3;
  localparam int REP_SPACE_U    = 4;

  function automatic logic isMark(input nec_state_e state);
    return (state == LEADER_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier for the NEC transmitter; phase restarts high on every envelope rising edge.
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic master_clk,
  input  logic reset,
  input  logic envelope,
  output logic carrier_out
);

  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          r_prevEnv;
  logic          w_rise;
  logic [CW-1:0] w_cnt;
  logic          w_phase;

  // On the first mark cycle the effective counter/phase are 0/high, so the mark starts with carrier high.
  assign w_rise      = envelope && !r_prevEnv;
  assign w_cnt       = w_rise ? '0 : r_cnt;
  assign w_phase     = w_rise ? 1'b1 : r_phase;
  assign carrier_out = w_phase;

  always_ff @(posedge master_clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_prevEnv <= 1'b0;
    end else begin
      r_prevEnv <= envelope;
      if (w_cnt == CW'(CARRIER_HALF - 1)) begin
        r_cnt   <= '0;
        r_phase <= ~w_phase;
      end else begin
        r_cnt   <= w_cnt + CW'(1);
        r_phase <= w_phase;
      end
    end
  end

endmodule

// File: rtl/ir_nec_transmit.sv
// NEC infrared transmitter: serialises a 32-bit word LSB-first into a modulated IR drive.
// Optional repeat-frame generation is enabled by defining IR_NEC_REPEAT_EN.
module ir_nec_transmit
  import ir_nec_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int GAP_UNITS    = 40
) (
  input  logic        master_clk,
  input  logic        reset,
  input  logic        send_valid,
  input  logic [31:0] send_data,
  output logic        send_ready,
  output logic        ir_envelope,
  output logic        ir_tx,
  output logic        frame_done
);

  localparam int CYCW  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int MAXU  = (GAP_UNITS > LEADER_MARK_U) ? GAP_UNITS : LEADER_MARK_U;
  localparam int UNITW = $clog2(MAXU + 1);

  nec_state_e       r_state;
  nec_state_e       w_nextState;
  logic [CYCW-1:0]  r_cycCnt;
  logic [UNITW-1:0] r_unitCnt;
  logic [UNITW-1:0] w_dur;
  logic [31:0]      r_shift;
  logic [4:0]       r_bitIdx;
  logic             w_accept;
  logic             w_stateEnd;
  logic             w_repeat;
  logic             w_carrier;

`ifdef IR_NEC_REPEAT_EN
  logic [31:0] r_lastWord;
  logic        r_repeat;
  assign w_repeat = r_repeat;
`else
  assign w_repeat = 1'b0;
`endif

  assign w_accept   = send_valid && (r_state == IDLE);
  assign w_stateEnd = (r_cycCnt == CYCW'(UNIT_CYCLES - 1)) && (r_unitCnt == w_dur - UNITW'(1));

  always_comb begin
    w_nextState = r_state;
    w_dur       = UNITW'(1);
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = LEADER_MARK;
      end
      LEADER_MARK: begin
        w_dur = UNITW'(LEADER_MARK_U);
        if (w_stateEnd) w_nextState = w_repeat ? REP_SPACE : LEADER_SPACE;
      end
      LEADER_SPACE: begin
        w_dur = UNITW'(LEADER_SPACE_U);
        if (w_stateEnd) w_nextState = BIT_MARK;
      end
      BIT_MARK: begin
        if (w_stateEnd) w_nextState = BIT_SPACE;
      end
      BIT_SPACE: begin
        w_dur = r_shift[0] ? UNITW'(ONE_SPACE_U) : UNITW'(ZERO_SPACE_U);
        if (w_stateEnd) w_nextState = (r_bitIdx == 5'd31) ? STOP_MARK : BIT_MARK;
      end
      STOP_MARK: begin
        if (w_stateEnd) w_nextState = GAP;
      end
      GAP: begin
        w_dur = UNITW'(GAP_UNITS);
        if (w_stateEnd) begin
          w_nextState = IDLE;
`ifdef IR_NEC_REPEAT_EN
          if (send_valid && (send_data == r_lastWord)) w_nextState = LEADER_MARK;
`endif
        end
      end
      REP_SPACE: begin
        w_dur = UNITW'(REP_SPACE_U);
        if (w_stateEnd) w_nextState = STOP_MARK;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Timing counters restart at every state change, so durations are exact multiples of the unit.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cycCnt  <= '0;
      r_unitCnt <= '0;
      r_shift   <= '0;
      r_bitIdx  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_stateEnd || (r_state == IDLE)) begin
        r_cycCnt  <= '0;
        r_unitCnt <= '0;
      end else if (r_cycCnt == CYCW'(UNIT_CYCLES - 1)) begin
        r_cycCnt  <= '0;
        r_unitCnt <= r_unitCnt + UNITW'(1);
      end else begin
        r_cycCnt <= r_cycCnt + CYCW'(1);
      end
      if (w_accept) begin
        r_shift  <= send_data;
        r_bitIdx <= '0;
      end else if ((r_state == BIT_SPACE) && w_stateEnd) begin
        r_shift  <= r_shift >> 1;
        r_bitIdx <= r_bitIdx + 5'd1;
      end
    end
  end

`ifdef IR_NEC_REPEAT_EN
  always_ff @(posedge master_clk) begin
    if (reset) begin
      r_lastWord <= '0;
      r_repeat   <= 1'b0;
    end else if (w_accept) begin
      r_lastWord <= send_data;
      r_repeat   <= 1'b0;
    end else if ((r_state == GAP) && w_stateEnd) begin
      r_repeat <= (w_nextState == LEADER_MARK);
    end
  end
`endif

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .master_clk (master_clk),
    .reset      (reset),
    .envelope   (ir_envelope),
    .carrier_out(w_carrier)
  );

  assign send_ready  = (r_state == IDLE);
  assign ir_envelope = isMark(r_state);
  assign ir_tx       = ir_envelope && w_carrier;
  assign frame_done  = (r_state == STOP_MARK) && w_stateEnd;

endmodule

// File: tb/tb_ir_nec_transmit.sv
// Randomized self-checking bench for ir_nec_transmit against a per-cycle waveform model.
module tb_ir_nec_transmit;

  localparam int UC = 4;
  localparam int CH = 3;
  localparam int GU = 40;

  logic        master_clk = 1'b0;
  logic        reset      = 1'b1;
  logic        send_valid = 1'b0;
  logic [31:0] send_data  = '0;
  logic        send_ready;
  logic        ir_envelope;
  logic        ir_tx;
  logic        frame_done;

  int compareCount = 0;
  int failCount    = 0;
  bit expEnv[$];
  bit expTx[$];

  ir_nec_transmit #(
    .UNIT_CYCLES (UC),
    .CARRIER_HALF(CH),
    .GAP_UNITS   (GU)
  ) dut (
    .master_clk (master_clk),
    .reset      (reset),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_ready (send_ready),
    .ir_envelope(ir_envelope),
    .ir_tx      (ir_tx),
    .frame_done (frame_done)
  );

  always #5 master_clk = ~master_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  // One segment of the expected waveform; each mark restarts the carrier high.
  task automatic addSeg(input bit level, input int units);
    for (int k = 0; k < units * UC; k++) begin
      expEnv.push_back(level);
      expTx.push_back(level && (((k / CH) % 2) == 0));
    end
  endtask

  task automatic buildModel(input logic [31:0] word);
    expEnv.delete();
    expTx.delete();
    addSeg(1'b1, 16);
    addSeg(1'b0, 8);
    for (int b = 0; b < 32; b++) begin
      addSeg(1'b1, 1);
      addSeg(1'b0, word[b] ? 3 : 1);
    end
    addSeg(1'b1, 1);
    addSeg(1'b0, GU);
  endtask

  // Sends one word and checks every cycle up to and including the cycle where send_ready returns.
  task automatic applyStimulus(input logic [31:0] word, input bit scramble, input bit holdValid);
    int n, len, doneIdx, expDoneIdx, readyIdx;
    int envBad, txBad, readyBad, doneCnt, frameOnes;
    send_data  = word;
    send_valid = 1'b1;
    n = 0;
    while (send_ready !== 1'b1 && n < 2000) begin
      @(negedge master_clk);
      n++;
    end
    checkOutput("acceptReady", {31'd0, send_ready}, 32'd1);
    buildModel(word);
    len        = expEnv.size();
    frameOnes  = $countones(word);
    expDoneIdx = (25 + 64 + 2 * frameOnes) * UC - 1;
    doneIdx = -1; readyIdx = -1;
    envBad = 0; txBad = 0; readyBad = 0; doneCnt = 0;
    for (int c = 0; c <= len; c++) begin
      @(negedge master_clk);
      if (c < len) begin
        if (ir_envelope !== expEnv[c]) envBad++;
        if (ir_tx !== expTx[c]) txBad++;
        if (send_ready !== 1'b0) readyBad++;
        if (frame_done === 1'b1) begin
          doneCnt++;
          if (doneIdx < 0) doneIdx = c;
        end
        if (scramble) send_data = $urandom;
        else if (!holdValid) send_valid = 1'b0;
      end else begin
        if (send_ready === 1'b1) readyIdx = c;
      end
    end
    checkOutput("envelope", envBad, 0);
    checkOutput("carrier", txBad, 0);
    checkOutput("busyReady", readyBad, 0);
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("doneIndex", doneIdx, expDoneIdx);
    checkOutput("gapToReady", readyIdx - doneIdx, GU * UC + 1);
    if (!holdValid) send_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge master_clk);
    checkOutput("rstReady", {31'd0, send_ready}, 32'd1);
    checkOutput("rstEnv", {31'd0, ir_envelope}, 32'd0);
    checkOutput("rstTx", {31'd0, ir_tx}, 32'd0);
    checkOutput("rstDone", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    @(negedge master_clk);

    applyStimulus(32'h0000_0000, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b1);
    applyStimulus(32'hF708_FF00, 1'b1, 1'b0);

    // Reset during the leader space must abort the frame immediately.
    send_data  = $urandom;
    send_valid = 1'b1;
    for (int n = 0; n < 2000 && send_ready !== 1'b1; n++) @(negedge master_clk);
    for (int c = 0; c <= 16 * UC + 2; c++) @(negedge master_clk);
    checkOutput("leaderSpaceEnv", {31'd0, ir_envelope}, 32'd0);
    send_valid = 1'b0;
    reset      = 1'b1;
    @(negedge master_clk);
    checkOutput("midRstReady", {31'd0, send_ready}, 32'd1);
    checkOutput("midRstEnv", {31'd0, ir_envelope}, 32'd0);
    checkOutput("midRstTx", {31'd0, ir_tx}, 32'd0);
    reset = 1'b0;
    @(negedge master_clk);
    checkOutput("postRstReady", {31'd0, send_ready}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom, (i % 2) == 0, i < 5);
    end

    repeat (5) @(negedge master_clk);
    checkOutput("idleEnv", {31'd0, ir_envelope}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/ir_nec_transmit.md
Name: ir_nec_transmit

Overview:
- NEC-format infrared transmitter. It is the send-side counterpart of the IR_RECEIVE decoder.
- Takes a 32-bit word in the same layout the receiver outputs: [15:0] custom code, [23:16] key, [31:24] ~key.
- Serialises the word LSB-first into a 38 kHz-modulated IR drive signal.
- Sits on master_clk (50 MHz). Used for board-to-board control and as a loopback stimulus source for the receiver.

Parameters:
- UNIT_CYCLES, 28125: master_clk cycles per NEC time unit (562.5 us at 50 MHz).
- CARRIER_HALF, 658: master_clk cycles per carrier half-period (about 38 kHz).
- GAP_UNITS, 40: minimum idle units after the stop mark before send_ready reasserts.

Ports:
- master_clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- send_valid  in  1  request to transmit send_data
- send_data  in  32  frame word, bit 0 sent first
- send_ready  out  1  high when a new frame can be accepted
- ir_envelope  out  1  unmodulated mark/space envelope (1 = mark)
- ir_tx  out  1  modulated IR LED drive, equal to ir_envelope AND carrier
- frame_done  out  1  one-cycle pulse at the end of the stop mark

Behaviour:
- One clock, master_clk. Reset is synchronous and active-high. It wins over every other event, including mid-frame.
- On reset: state IDLE, send_ready=1, ir_envelope=0, ir_tx=0, frame_done=0, all counters 0, shift register 0.
- Accept when send_valid && send_ready are both high on a rising edge:
  - send_data is latched into a 32-bit shift register.
  - send_ready=0 from the next cycle.
  - ir_envelope=1 from the next cycle; the first leader-mark cycle follows acceptance.
- send_data and send_valid are ignored while send_ready=0.
- States and durations, in units of UNIT_CYCLES:
  - LEADER_MARK: 16
  - LEADER_SPACE: 8
  - BIT_MARK: 1
  - BIT_SPACE: 1 if the current bit is 0, 3 if it is 1
  - STOP_MARK: 1
  - GAP: GAP_UNITS
  - then IDLE
- The bit index runs 0..31. After the BIT_SPACE of bit 31, the next state is STOP_MARK; otherwise it is BIT_MARK. The shift register shifts right at the end of each BIT_SPACE.
- Timing counter: the cycle counter counts 0..UNIT_CYCLES-1 and the unit counter counts units per state. Both clear on every state change. Durations are exact with no drift; LEADER_MARK is 16*UNIT_CYCLES cycles.
- ir_envelope=1 exactly in the LEADER_MARK, BIT_MARK and STOP_MARK states.
- Carrier generation:
  - Carrier counter 0..CARRIER_HALF-1; carrier phase toggles on wrap.
  - Counter and phase are forced to 0 / phase 1 on every envelope rising edge, so every mark starts with carrier high.
  - ir_tx=0 whenever ir_envelope=0.
- frame_done pulses on the last cycle of STOP_MARK.
- send_ready=1 again on the cycle after GAP completes. Back-to-back valid is therefore accepted on that cycle.
- Total frame length (mark+space, excluding GAP) = 25 + 32*2 + 2*(number of ones) units. All-zero data gives 89 units; all-ones gives 153 units.

Optional Feature:
- Macro: IR_NEC_REPEAT_EN.
- Defined:
  - If send_valid is still high when GAP ends and the previous word is unchanged, the block sends an NEC repeat frame instead of idling.
  - Repeat frame: 16-unit mark, 4-unit space, 1-unit mark, frame_done pulse, then GAP.
  - send_ready stays 0 during repeats.
  - Dropping send_valid ends repeats at the next GAP boundary.
- Undefined: no repeat logic; behaviour exactly as above.

Decomposition:
- Package ir_nec_pkg holds:
  - the state enum (IDLE, LEADER_MARK, LEADER_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP, REP_SPACE);
  - unit-count constants LEADER_MARK_U=16, LEADER_SPACE_U=8, ZERO_SPACE_U=1, ONE_SPACE_U=3, REP_SPACE_U=4.
- Sub-module ir_carrier_gen (params CARRIER_HALF; inputs master_clk, reset, envelope; output carrier_out) isolates the 38 kHz modulator.

Test Plan:
- Reset mid-frame: assert reset during LEADER_SPACE -> next cycle send_ready=1, ir_envelope=0, ir_tx=0. A new send is then accepted normally.
- Basic frame: send_data=32'h00000000, UNIT_CYCLES=4, CARRIER_HALF=1 -> 89 units between acceptance and frame_done. Envelope high for 16 units, low 8, then 32 pairs of 1-unit mark / 1-unit space, then 1-unit stop mark.
- All ones: send_data=32'hFFFFFFFF -> every BIT_SPACE lasts 3 units; frame_done occurs 153 units after acceptance.
- Receiver loopback: send_data=32'hF708FF00 (key 8'h08) through IR_RECEIVE at default parameters -> oDATA_READY asserted and oDATA=32'hF708FF00.
- Handshake:
  - send_valid held high with changing send_data during a frame -> only the first word is transmitted.
  - Second word accepted exactly GAP_UNITS*UNIT_CYCLES cycles after frame_done +1.
- Carrier check: during LEADER_MARK, ir_tx toggles every CARRIER_HALF cycles, starting high. During spaces ir_tx=0. With IR_NEC_REPEAT_EN and send_valid held, a 16/4/1 repeat frame follows GAP.
